uart_tx_arb: RTL and testbench
==============================

// Module: uart_tx_arb
// PURPOSE
//  Shares the single uart_tx instance between N_REQ byte-stream requesters (e.g. rx echo
//  path, status/banner generator). Grants are packet-granular: once a requester is granted,
//  it owns uart_tx until it presents a byte with in_last, or until MAX_PKT bytes pass.
//  Grants rotate round-robin. Bytes are gated by the RS232 CTS line (synchronized inside).
// PARAMETERS
//  N_REQ       2     number of requesters, 2..8
//  MAX_PKT     64    max bytes per grant before forced release, 1..255
//  CTS_EN      1     1: gate bytes on uart_cts; 0: ignore uart_cts
//  CTS_ACTIVE  1     uart_cts level that means "clear to send"
// PORTS
//  clk         in   1        system clock (25 MHz in current design)
//  reset_      in   1        asynchronous active-low reset
//  in_req      in   N_REQ    per-requester byte valid
//  in_ready    out  N_REQ    per-requester byte accepted (transfer = in_req & in_ready)
//  in_data     in   8*N_REQ  requester i byte on bits [8*i+7:8*i]
//  in_last     in   N_REQ    qualifies in_data as last byte of packet
//  tx_req      out  1        to uart_tx tx_req
//  tx_ready    in   1        from uart_tx tx_ready
//  tx_data     out  8        to uart_tx tx_data
//  uart_cts    in   1        raw RS232 CTS, asynchronous
//  grant       out  N_REQ    one-hot current owner, 0 when idle
//  busy        out  1        1 while in LOCKED
// BEHAVIOUR
//  Reset (async, reset_=0): state IDLE, grant=0, busy=0, tx_req=0, in_ready=0, tx_data=0,
//   byte_cnt=0, rr_ptr=N_REQ-1 (requester 0 has top priority first), CTS sync flops=~CTS_ACTIVE.
//   Reset mid-packet aborts the grant; the byte already inside uart_tx is not our concern.
//  CTS: 2-flop synchronizer; cts_ok = !CTS_EN | (cts_sync == CTS_ACTIVE). 2-3 cycle latency.
//  Handshake (both sides): transfer when req & ready in same cycle; requesters hold in_req,
//   in_data, in_last stable until transfer. No byte is dropped or duplicated.
//  FSM IDLE:
//   - tx_req=0, in_ready=0. If cts_ok and |in_req: pick first i with in_req[i] scanning
//     rr_ptr+1, rr_ptr+2, ... (mod N_REQ); register grant=1<<i, byte_cnt=0, go LOCKED.
//   - Grant decision takes 1 cycle: req seen at cycle n -> tx_req earliest at n+1.
//   - If !cts_ok, stay IDLE regardless of requests.
//  FSM LOCKED (owner g):
//   - Combinational: tx_data=in_data[g], tx_req=in_req[g] & cts_ok,
//     in_ready[g]=tx_ready & cts_ok, all other in_ready=0.
//   - CTS drop mid-packet: byte-level stall (tx_req=0) while keeping grant; resumes on cts_ok.
//   - On transfer: byte_cnt<=byte_cnt+1 (8-bit, no wrap since release happens first).
//     If in_last[g] or byte_cnt+1==MAX_PKT: grant<=0, rr_ptr<=g, go IDLE.
//   - Release cycle is a mandatory IDLE cycle: back-to-back packets from owners cost 1 idle clk.
//   - Owner dropping in_req without last: grant held (no timeout beyond MAX_PKT bytes).
//  Fairness: after g releases, every other pending requester is served before g again.
//  tx_data is 0 whenever grant==0. grant and busy are registered outputs.
// TESTING
//  1 Reset: reset_=0 with in_req=2'b11 -> grant=0, tx_req=0, in_ready=0; release reset,
//    cts ok -> grant=2'b01 at 2nd clk after cts_sync valid.
//  2 Single packet: req0 sends 0x41,0x42,0x43(last), tx_ready pulses -> uart_tx gets exactly
//    41,42,43 in order; grant returns to 0 for 1 clk after 0x43 transfer.
//  3 Round-robin: both req, 3-byte packets each, continuous -> order pkt0,pkt1,pkt0,pkt1;
//    no byte of pkt1 appears between bytes of pkt0.
//  4 MAX_PKT=4, req0 streams 10 bytes never last, req1 pending -> grant switches to req1
//    after 4th byte of req0; req0 resumes with 5th byte after req1's packet.
//  5 CTS: deassert uart_cts before byte 2 of 3 -> tx_req low within 3 clks, grant held;
//    reassert -> bytes 2,3 delivered; CTS low in IDLE with req -> grant stays 0.
//  6 Async reset mid-packet (after byte 1 of 3) -> all outputs 0 immediately (no clk edge);
//    after reset, req0 packet restarts cleanly from its current held byte.

Source files
------------

// File: rtl/uart_tx_arb.sv
// Packet-granular round-robin arbiter sharing one uart_tx between N_REQ byte streams.
// Byte flow toward uart_tx is gated by a synchronized RS232 CTS input.
module uart_tx_arb #(
  parameter int N_REQ      = 2,
  parameter int MAX_PKT    = 64,
  parameter int CTS_EN     = 1,
  parameter int CTS_ACTIVE = 1
) (
  input  logic                 clk,
  input  logic                 reset_,
  input  logic [N_REQ-1:0]     in_req,
  output logic [N_REQ-1:0]     in_ready,
  input  logic [8*N_REQ-1:0]   in_data,
  input  logic [N_REQ-1:0]     in_last,
  output logic                 tx_req,
  input  logic                 tx_ready,
  output logic [7:0]           tx_data,
  input  logic                 uart_cts,
  output logic [N_REQ-1:0]     grant,
  output logic                 busy
);

  localparam int                IDXW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic              CTS_ON  = (CTS_ACTIVE != 0);
  localparam logic              CTS_OFF = ~CTS_ON;
  localparam logic [7:0]        MAX_CNT = 8'(MAX_PKT);
  localparam logic [IDXW-1:0]   RR_INIT = IDXW'(N_REQ - 1);
  localparam logic [N_REQ-1:0]  ONE_HOT = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state_r, state_n;
  logic [N_REQ-1:0] grant_r, grant_n;
  logic [IDXW-1:0]  owner_r, owner_n;
  logic [IDXW-1:0]  rr_ptr_r, rr_ptr_n;
  logic [7:0]       byte_cnt_r, byte_cnt_n;
  logic             busy_r;
  logic             cts_meta_r, cts_sync_r;
  logic             cts_ok_s;
  logic             pick_valid_s;
  logic [IDXW-1:0]  pick_idx_s;
  logic             xfer_s;

  // First requesting index after ptr, wrapping; MSB of the result flags a hit.
  function automatic logic [IDXW:0] rr_pick(input logic [N_REQ-1:0] req,
                                            input logic [IDXW-1:0]  ptr);
    logic            found;
    logic [IDXW-1:0] idx;
    int              cand;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = (int'(ptr) + k) % N_REQ;
      if (!found && req[cand[IDXW-1:0]]) begin
        found = 1'b1;
        idx   = cand[IDXW-1:0];
      end
    end
    return {found, idx};
  endfunction

  assign {pick_valid_s, pick_idx_s} = rr_pick(in_req, rr_ptr_r);
  assign cts_ok_s = (CTS_EN == 0) ? 1'b1 : (cts_sync_r == CTS_ON);
  assign grant    = grant_r;
  assign busy     = busy_r;

  // Two-flop synchronizer for the asynchronous CTS pin, reset to "not clear".
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      cts_meta_r <= CTS_OFF;
      cts_sync_r <= CTS_OFF;
    end else begin
      cts_meta_r <= uart_cts;
      cts_sync_r <= cts_meta_r;
    end
  end

  // Arbiter state, grant bookkeeping and registered status outputs.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_r    <= IDLE;
      grant_r    <= '0;
      owner_r    <= '0;
      rr_ptr_r   <= RR_INIT;
      byte_cnt_r <= 8'd0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_n;
      grant_r    <= grant_n;
      owner_r    <= owner_n;
      rr_ptr_r   <= rr_ptr_n;
      byte_cnt_r <= byte_cnt_n;
      busy_r     <= (state_n == LOCKED);
    end
  end

  // Next-state logic plus the combinational byte path from the owner to uart_tx.
  always_comb begin
    state_n    = state_r;
    grant_n    = grant_r;
    owner_n    = owner_r;
    rr_ptr_n   = rr_ptr_r;
    byte_cnt_n = byte_cnt_r;
    tx_req     = 1'b0;
    tx_data    = 8'h00;
    in_ready   = '0;
    xfer_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (cts_ok_s && pick_valid_s) begin
          grant_n    = ONE_HOT << pick_idx_s;
          owner_n    = pick_idx_s;
          byte_cnt_n = 8'd0;
          state_n    = LOCKED;
        end else begin
          state_n = IDLE;
        end
      end
      LOCKED: begin
        tx_data           = in_data[{owner_r, 3'b000} +: 8];
        tx_req            = in_req[owner_r] & cts_ok_s;
        in_ready[owner_r] = tx_ready & cts_ok_s;
        xfer_s            = tx_req & tx_ready;
        if (xfer_s) begin
          byte_cnt_n = byte_cnt_r + 8'd1;
          // Releasing always passes through IDLE, so the next owner costs one idle clock.
          if (in_last[owner_r] || (byte_cnt_n == MAX_CNT)) begin
            grant_n  = '0;
            rr_ptr_n = owner_r;
            state_n  = IDLE;
          end else begin
            state_n = LOCKED;
          end
        end else begin
          state_n = LOCKED;
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: directed scenarios plus randomized traffic
// compared against a rule-level arbitration model and per-requester byte scoreboards.
module tb_uart_tx_arb;

  localparam int MAXP = 4;

  logic        clk = 1'b0;
  logic        reset_;
  logic [1:0]  in_req, in_ready, in_last, grant;
  logic [15:0] in_data;
  logic        tx_req, tx_ready, uart_cts, busy;
  logic [7:0]  tx_data;

  always #5 clk = ~clk;

  uart_tx_arb #(.N_REQ(2), .MAX_PKT(MAXP), .CTS_EN(1), .CTS_ACTIVE(1)) dut (
    .clk(clk), .reset_(reset_), .in_req(in_req), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .tx_req(tx_req), .tx_ready(tx_ready),
    .tx_data(tx_data), .uart_cts(uart_cts), .grant(grant), .busy(busy)
  );

  int         checks = 0;
  int         failures = 0;
  logic [8:0] q0[$], q1[$];
  logic [7:0] gen0[$], gen1[$];
  logic [8:0] sink[$];
  logic [1:0] en_v;
  logic       rdy_v, cts_v;
  logic       xfer, xfer_own;
  logic [7:0] xfer_byte;
  logic       ch1, ch2;

  task automatic push_pkt(input int i, input logic [7:0] base, input int len, input bit with_last);
    for (int k = 0; k < len; k++) begin
      logic [8:0] e;
      e = {(with_last && (k == len - 1)), base + 8'(k)};
      if (i == 0) begin q0.push_back(e); gen0.push_back(e[7:0]); end
      else begin q1.push_back(e); gen1.push_back(e[7:0]); end
    end
  endtask

  task automatic clear_all();
    q0.delete(); q1.delete(); gen0.delete(); gen1.delete(); sink.delete();
  endtask

  task automatic drive_inputs();
    in_req[0]     = en_v[0] && (q0.size() > 0);
    in_req[1]     = en_v[1] && (q1.size() > 0);
    in_data[7:0]  = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
    in_data[15:8] = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
    in_last[0]    = (q0.size() > 0) ? q0[0][8] : 1'b0;
    in_last[1]    = (q1.size() > 0) ? q1[0][8] : 1'b0;
    tx_ready      = rdy_v;
    uart_cts      = cts_v;
  endtask

  // One clock: commit the transfer seen last cycle, drive new inputs, sample after negedge.
  task automatic tick();
    logic [8:0] d;
    @(posedge clk); #1;
    if (xfer) begin
      sink.push_back({xfer_own, xfer_byte});
      if (xfer_own == 1'b0) d = q0.pop_front(); else d = q1.pop_front();
    end
    ch2 = ch1;
    ch1 = uart_cts;
    @(negedge clk);
    drive_inputs();
    #1;
    xfer      = tx_req && tx_ready;
    xfer_own  = grant[1];
    xfer_byte = tx_data;
  endtask

  task automatic do_reset();
    reset_ = 1'b0; xfer = 1'b0; ch1 = 1'b0; ch2 = 1'b0;
    drive_inputs();
    repeat (2) @(negedge clk);
    reset_ = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    logic [1:0] exp;
    clear_all(); rdy_v = 1'b0; cts_v = 1'b1;
    push_pkt(0, 8'h55, 1, 1); push_pkt(1, 8'h66, 1, 1);
    reset_ = 1'b0; xfer = 1'b0; ch1 = 1'b0; ch2 = 1'b0;
    drive_inputs();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (grant !== 2'b00 || busy !== 1'b0) begin
      failures++; $display("FAIL reset_status: grant=%b busy=%b, expected 00/0", grant, busy);
    end
    checks++;
    if (tx_req !== 1'b0 || in_ready !== 2'b00 || tx_data !== 8'h00) begin
      failures++; $display("FAIL reset_outputs: tx_req=%b in_ready=%b tx_data=%h, expected 0/00/00", tx_req, in_ready, tx_data);
    end
    @(negedge clk); reset_ = 1'b1; #1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      exp = (c == 3) ? 2'b01 : 2'b00;
      checks++;
      if (grant !== exp) begin
        failures++; $display("FAIL reset_grant_clk%0d: grant=%b, expected %b", c, grant, exp);
      end
    end
    checks++;
    if (tx_req !== 1'b1 || tx_data !== 8'h55 || busy !== 1'b1) begin
      failures++; $display("FAIL reset_first_owner: tx_req=%b tx_data=%h busy=%b, expected 1/55/1", tx_req, tx_data, busy);
    end
  endtask

  task automatic test_single_packet();
    bit pend;
    bit seen;
    clear_all(); rdy_v = 1'b0; cts_v = 1'b1; pend = 1'b0; seen = 1'b0;
    do_reset(); repeat (3) tick();
    push_pkt(0, 8'h41, 3, 1);
    for (int c = 0; c < 60 && sink.size() < 3; c++) begin
      rdy_v = c[0];
      tick();
      if (pend) begin
        seen = 1'b1; pend = 1'b0; checks++;
        if (grant !== 2'b00) begin
          failures++; $display("FAIL single_release_idle: grant=%b, expected 00", grant);
        end
      end
      if (xfer && in_last[0]) pend = 1'b1;
    end
    checks++;
    if (sink.size() != 3 || !seen) begin
      failures++; $display("FAIL single_count: bytes=%0d released=%0d, expected 3/1", sink.size(), seen);
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (sink[k] !== {1'b0, 8'h41 + 8'(k)}) begin
          failures++; $display("FAIL single_byte%0d: got %h, expected %h", k, sink[k], {1'b0, 8'h41 + 8'(k)});
        end
      end
    end
  endtask

  task automatic test_round_robin();
    int         idle;
    logic [8:0] exp;
    logic [7:0] bases [4];
    clear_all(); rdy_v = 1'b1; cts_v = 1'b1; idle = 0;
    bases[0] = 8'hA0; bases[1] = 8'hB0; bases[2] = 8'hC0; bases[3] = 8'hD0;
    do_reset(); repeat (3) tick();
    push_pkt(0, 8'hA0, 3, 1); push_pkt(0, 8'hC0, 3, 1);
    push_pkt(1, 8'hB0, 3, 1); push_pkt(1, 8'hD0, 3, 1);
    for (int c = 0; c < 80 && sink.size() < 12; c++) begin
      tick();
      if (grant == 2'b00) idle++;
    end
    checks++;
    if (sink.size() != 12 || idle != 5) begin
      failures++; $display("FAIL rr_count: bytes=%0d idle_clks=%0d, expected 12/5", sink.size(), idle);
    end else begin
      for (int k = 0; k < 12; k++) begin
        exp = {((k / 3) % 2 == 1), bases[k / 3] + 8'(k % 3)};
        checks++;
        if (sink[k] !== exp) begin
          failures++; $display("FAIL rr_byte%0d: got %h, expected %h", k, sink[k], exp);
        end
      end
    end
  endtask

  task automatic test_max_pkt();
    logic [8:0] exp [12];
    clear_all(); rdy_v = 1'b1; cts_v = 1'b1;
    for (int k = 0; k < 4; k++) exp[k] = {1'b0, 8'h10 + 8'(k)};
    exp[4] = {1'b1, 8'hB0}; exp[5] = {1'b1, 8'hB1};
    for (int k = 6; k < 12; k++) exp[k] = {1'b0, 8'h10 + 8'(k - 2)};
    do_reset(); repeat (3) tick();
    push_pkt(0, 8'h10, 10, 0); push_pkt(1, 8'hB0, 2, 1);
    for (int c = 0; c < 100 && sink.size() < 12; c++) tick();
    checks++;
    if (sink.size() != 12) begin
      failures++; $display("FAIL maxpkt_count: bytes=%0d, expected 12", sink.size());
    end else begin
      for (int k = 0; k < 12; k++) begin
        checks++;
        if (sink[k] !== exp[k]) begin
          failures++; $display("FAIL maxpkt_byte%0d: got %h, expected %h", k, sink[k], exp[k]);
        end
      end
    end
    repeat (3) tick();
    checks++;
    if (grant !== 2'b01 || tx_req !== 1'b0) begin
      failures++; $display("FAIL maxpkt_hold: grant=%b tx_req=%b, expected 01/0", grant, tx_req);
    end
  endtask

  task automatic test_cts();
    clear_all(); rdy_v = 1'b1; cts_v = 1'b1;
    do_reset(); repeat (3) tick();
    push_pkt(0, 8'h61, 3, 1);
    for (int c = 0; c < 20 && !(xfer && xfer_byte == 8'h61); c++) tick();
    checks++;
    if (!(xfer && xfer_byte == 8'h61)) begin
      failures++; $display("FAIL cts_first_byte: xfer=%b byte=%h, expected 1/61", xfer, xfer_byte);
    end
    rdy_v = 1'b0; cts_v = 1'b0;
    repeat (3) tick();
    checks++;
    if (tx_req !== 1'b0 || grant !== 2'b01 || busy !== 1'b1) begin
      failures++; $display("FAIL cts_stall: tx_req=%b grant=%b busy=%b, expected 0/01/1", tx_req, grant, busy);
    end
    rdy_v = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (tx_req !== 1'b0 || in_ready !== 2'b00 || grant !== 2'b01) begin
        failures++; $display("FAIL cts_hold%0d: tx_req=%b in_ready=%b grant=%b, expected 0/00/01", c, tx_req, in_ready, grant);
      end
    end
    cts_v = 1'b1;
    for (int c = 0; c < 20 && sink.size() < 3; c++) tick();
    checks++;
    if (sink.size() != 3 || sink[1] !== 9'h062 || sink[2] !== 9'h063) begin
      failures++; $display("FAIL cts_resume: bytes=%0d, expected 3 ending 062 063", sink.size());
    end
    cts_v = 1'b0;
    repeat (3) tick();
    push_pkt(1, 8'h91, 1, 1);
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (grant !== 2'b00) begin
        failures++; $display("FAIL cts_idle%0d: grant=%b, expected 00", c, grant);
      end
    end
    cts_v = 1'b1;
    for (int c = 0; c < 20 && sink.size() < 4; c++) tick();
    checks++;
    if (sink.size() != 4 || sink[3] !== 9'h191) begin
      failures++; $display("FAIL cts_idle_release: bytes=%0d, expected 4 ending 191", sink.size());
    end
  endtask

  task automatic test_async_reset();
    clear_all(); rdy_v = 1'b1; cts_v = 1'b1;
    do_reset(); repeat (3) tick();
    push_pkt(0, 8'h71, 3, 1);
    for (int c = 0; c < 20 && sink.size() < 1; c++) tick();
    reset_ = 1'b0;
    #1;
    checks++;
    if (grant !== 2'b00 || busy !== 1'b0 || tx_req !== 1'b0) begin
      failures++; $display("FAIL areset_status: grant=%b busy=%b tx_req=%b, expected 00/0/0", grant, busy, tx_req);
    end
    checks++;
    if (in_ready !== 2'b00 || tx_data !== 8'h00) begin
      failures++; $display("FAIL areset_data: in_ready=%b tx_data=%h, expected 00/00", in_ready, tx_data);
    end
    do_reset();
    for (int c = 0; c < 30 && sink.size() < 3; c++) tick();
    checks++;
    if (sink.size() != 3 || sink[0] !== 9'h071 || sink[1] !== 9'h072 || sink[2] !== 9'h073) begin
      failures++; $display("FAIL areset_restart: bytes=%0d, expected 071 072 073", sink.size());
    end
  endtask

  task automatic test_random_traffic();
    logic [1:0] pg, preq, expg, exp_rdy;
    logic       pok, pxf, plast, ok, exp_req;
    logic [7:0] exp_data;
    int         seg, lastown, g, idx, i0, i1, bad0, bad1;
    bit         found;
    clear_all(); rdy_v = 1'b1; cts_v = 1'b1;
    do_reset();
    pg = 2'b00; preq = 2'b00; pok = 1'b0; pxf = 1'b0; plast = 1'b0; seg = 0; lastown = 1;
    for (int c = 0; c < 4000; c++) begin
      if (q0.size() == 0 && $urandom_range(0, 3) == 0)
        push_pkt(0, 8'($urandom), int'($urandom_range(1, 6)), $urandom_range(0, 4) != 0);
      if (q1.size() == 0 && $urandom_range(0, 3) == 0)
        push_pkt(1, 8'($urandom), int'($urandom_range(1, 6)), $urandom_range(0, 4) != 0);
      rdy_v = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 29) == 0) cts_v = ~cts_v;
      tick();
      ok = ch2;
      if (pg == 2'b00) begin
        expg = 2'b00;
        if (pok && preq != 2'b00) begin
          found = 1'b0;
          for (int k = 1; k <= 2; k++) begin
            idx = (lastown + k) % 2;
            if (!found && preq[idx]) begin found = 1'b1; expg = 2'b01 << idx; end
          end
          seg = 0;
        end
      end else if (pxf) begin
        seg++;
        if (plast || seg == MAXP) begin expg = 2'b00; lastown = pg[1] ? 1 : 0; end
        else expg = pg;
      end else begin
        expg = pg;
      end
      checks++;
      if (grant !== expg || busy !== (expg != 2'b00)) begin
        failures++; $display("FAIL rand_grant@%0d: grant=%b busy=%b, expected %b", c, grant, busy, expg);
      end
      g = expg[1] ? 1 : 0;
      exp_data = (expg == 2'b00) ? 8'h00 : (g == 1 ? in_data[15:8] : in_data[7:0]);
      exp_req  = (expg != 2'b00) && in_req[g] && ok;
      exp_rdy  = (rdy_v && ok) ? expg : 2'b00;
      checks++;
      if (tx_data !== exp_data || tx_req !== exp_req || in_ready !== exp_rdy) begin
        failures++; $display("FAIL rand_path@%0d: tx_data=%h tx_req=%b in_ready=%b, expected %h/%b/%b", c, tx_data, tx_req, in_ready, exp_data, exp_req, exp_rdy);
      end
      pg = expg; preq = in_req; pok = ok;
      pxf = exp_req && rdy_v;
      plast = in_last[g];
    end
    i0 = 0; i1 = 0; bad0 = 0; bad1 = 0;
    foreach (sink[k]) begin
      if (sink[k][8] == 1'b0) begin
        if (i0 >= gen0.size() || sink[k][7:0] !== gen0[i0]) bad0++;
        i0++;
      end else begin
        if (i1 >= gen1.size() || sink[k][7:0] !== gen1[i1]) bad1++;
        i1++;
      end
    end
    checks++;
    if (bad0 != 0 || i0 + q0.size() != gen0.size()) begin
      failures++; $display("FAIL rand_stream0: bad=%0d sent=%0d queued=%0d generated=%0d", bad0, i0, q0.size(), gen0.size());
    end
    checks++;
    if (bad1 != 0 || i1 + q1.size() != gen1.size()) begin
      failures++; $display("FAIL rand_stream1: bad=%0d sent=%0d queued=%0d generated=%0d", bad1, i1, q1.size(), gen1.size());
    end
    checks++;
    if (sink.size() < 200) begin
      failures++; $display("FAIL rand_progress: bytes=%0d, expected at least 200", sink.size());
    end
  endtask

  initial begin
    reset_ = 1'b0; en_v = 2'b11; rdy_v = 1'b0; cts_v = 1'b1; xfer = 1'b0;
    xfer_own = 1'b0; xfer_byte = 8'h00; ch1 = 1'b0; ch2 = 1'b0;
    in_req = 2'b00; in_data = 16'h0000; in_last = 2'b00; tx_ready = 1'b0; uart_cts = 1'b1;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_max_pkt();
    test_cts();
    test_async_reset();
    test_random_traffic();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
